// File: rtl/fetch_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer.
// Owns the PC, instruction register and register-file write strobe.
module fetch_sequencer #(
  parameter int PC_WIDTH    = 6,
  parameter int INSTR_WIDTH = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   clkreset,
  input  logic                   start,
  input  logic                   stop,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_en,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  input  logic                   dec_we,
  input  logic                   dec_halt,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   ex_stall,
  output logic                   rf_we,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [2:0]             state,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   retire_count
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FETCH     = 3'd1;
  localparam logic [2:0] DECODE    = 3'd2;
  localparam logic [2:0] EXECUTE   = 3'd3;
  localparam logic [2:0] WRITEBACK = 3'd4;
  localparam logic [2:0] HALT      = 3'd5;

  logic [2:0] nxt;
  logic       stop_req;
  logic       we_q;

  assign imem_addr = pc;
  // we_q is cleared outside WRITEBACK, so it is the write strobe itself
  assign rf_we     = we_q;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (start && !stop) nxt = FETCH;
      FETCH:     nxt = DECODE;
      DECODE:    nxt = EXECUTE;
      EXECUTE:   if (!ex_stall) nxt = dec_halt ? HALT : WRITEBACK;
      WRITEBACK: nxt = (stop_req || stop) ? IDLE : FETCH;
      HALT: begin
        if (stop)       nxt = IDLE;
        else if (start) nxt = FETCH;
      end
      default:   nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clkreset) begin
    if (clkreset) begin
      state        <= IDLE;
      pc           <= '0;
      instr        <= '0;
      instr_valid  <= 1'b0;
      imem_en      <= 1'b0;
      halted       <= 1'b0;
      retire_count <= '0;
      stop_req     <= 1'b0;
      we_q         <= 1'b0;
    end else begin
      state   <= nxt;
      imem_en <= (nxt == FETCH);
      we_q    <= (state == EXECUTE) && (nxt == WRITEBACK) && dec_we;

      if (stop && (state == FETCH || state == DECODE || state == EXECUTE))
        stop_req <= 1'b1;

      case (state)
        DECODE: begin
          instr       <= imem_rdata;
          instr_valid <= 1'b1;
        end
        EXECUTE: begin
          if (!ex_stall && dec_halt) begin
            pc          <= pc + PC_WIDTH'(1);
            instr_valid <= 1'b0;
            halted      <= 1'b1;
          end
        end
        WRITEBACK: begin
          pc          <= branch_taken ? branch_target
                                      : pc + PC_WIDTH'(1);
          instr_valid <= 1'b0;
          stop_req    <= 1'b0;
          if (retire_count != '1)
            retire_count <= retire_count + CNT_WIDTH'(1);
        end
        HALT: begin
          if (start || stop) halted <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle controller that sequences the processor datapath through the FETCH, DECODE, EXECUTE and WRITEBACK stages. It owns the program counter and drives the instruction-memory address and enable. It latches the instruction register and gates the register-file write enable. Decode outputs from the control unit and the stall and branch inputs from the execute stage feed back into it.

Parameters:
PC_WIDTH, 6, program counter / instruction-memory address width (64 words)
INSTR_WIDTH, 32, instruction word width
CNT_WIDTH, 16, retired-instruction counter width

Ports:
clk  in  1  system clock, rising edge
clkreset  in  1  reset, asynchronous, active-high
start  in  1  level; begins or resumes execution from IDLE or HALT
stop  in  1  level; requests return to IDLE at the next instruction boundary
imem_addr  out  PC_WIDTH  instruction-memory read address
imem_en  out  1  instruction-memory read enable (synchronous read, 1-cycle latency)
imem_rdata  in  INSTR_WIDTH  instruction-memory read data
instr  out  INSTR_WIDTH  latched instruction register, feeds the control unit
instr_valid  out  1  instr holds the current instruction
dec_we  in  1  control-unit register-write enable for instr
dec_halt  in  1  control-unit halt decode for instr
branch_taken  in  1  execute-stage branch resolution
branch_target  in  PC_WIDTH  branch destination
ex_stall  in  1  execute stage not finished
rf_we  out  1  register-file write enable
pc  out  PC_WIDTH  current program counter
state  out  3  IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 WRITEBACK=4 HALT=5
halted  out  1  a halt instruction has been executed
retire_count  out  CNT_WIDTH  count of instructions completed through WRITEBACK

Behaviour:
- All outputs are registered, except imem_addr (always equal to pc).
- Reset (asynchronous, takes effect mid-operation as well):
  - state=IDLE, pc=0, instr=0, instr_valid=0, imem_en=0, rf_we=0, halted=0, retire_count=0, internal stop_req=0, we_q=0.
  - rf_we and imem_en drop immediately on assertion.
- IDLE: if start=1 and stop=0, go to FETCH. stop wins on simultaneous start and stop.
- FETCH (1 cycle): imem_en=1. Go to DECODE.
- DECODE (1 cycle): imem_en=0; instr<=imem_rdata; instr_valid<=1. Go to EXECUTE.
- EXECUTE:
  - While ex_stall=1, hold the state; pc and instr are unchanged.
  - On the first cycle with ex_stall=0 and dec_halt=1: pc<=pc+1, instr_valid<=0, halted<=1, go to HALT. There is no write and retire_count does not increment.
  - Otherwise, on ex_stall=0 and dec_halt=0: we_q<=dec_we, go to WRITEBACK.
- WRITEBACK (1 cycle):
  - rf_we=we_q (high for exactly this cycle).
  - pc<=branch_taken ? branch_target : pc+1.
  - retire_count<=retire_count+1, saturating at all-ones.
  - instr_valid<=0.
  - Next state is IDLE if stop_req or stop is set (clear stop_req), else FETCH.
- HALT:
  - start=1 clears halted and goes to FETCH at the already-advanced pc.
  - stop=1 clears halted and goes to IDLE; stop wins over start.
- stop_req: set when stop=1 in FETCH, DECODE or EXECUTE; honoured only at the WRITEBACK exit. An instruction in flight always completes.
- PC arithmetic: modulo 2^PC_WIDTH. pc=63 with +1 wraps to 0; a branch to 63 is legal.
- Minimum throughput is 4 cycles per instruction. Each ex_stall cycle adds one cycle.

Test Plan:
- Reset, start=1 held, memory word k = k, dec_we=1, no branches/stalls. Expect:
  - state sequence 1,2,3,4 repeating, imem_en high only in FETCH.
  - instr = 0,1,2,...; rf_we one cycle in every 4.
  - retire_count=5 after 20 cycles from first FETCH.
- pc=62 with sequential flow: pc goes 62 -> 63 -> 0 across two WRITEBACKs; imem_addr follows.
- EXECUTE with ex_stall high for 3 cycles, then branch_taken=1, branch_target=10: EXECUTE lasts 4 cycles, no rf_we during stall, then pc=10 and the next fetch is from address 10.
- dec_halt=1 at pc=5: HALT entered, halted=1, pc=6, rf_we never asserted, retire_count unchanged. Then start pulse: halted=0, fetch from address 6.
- stop pulsed during DECODE: current instruction completes WRITEBACK with rf_we, then state=IDLE; start and stop both high in IDLE keeps IDLE.
- clkreset asserted in WRITEBACK with rf_we=1: rf_we, state and pc go to 0 before the next clock edge. After release with start=1, fetch resumes from address 0.
